stopwatch_lap_ctrl: RTL and testbench
=====================================

# stopwatch_lap_ctrl

Mode controller for the stopwatch. It replaces the single-button start/stop controller with a two-button scheme: start/stop plus lap/reset. It drives the `clr`/`count`/`stop` controls of the time counter and captures split (lap) times into a small lap store. It also selects what the 5-digit dynamic display shows: live time, a frozen split, or a recalled lap. It sits between the two debounced button units and the counter/display, all on `sys_clk`.

## Interface
Parameters:
- `LAPS`, default 4: number of stored lap records; legal range 1..8.
- `LAP_W`, default 20: lap record width, packed as {mm[7:0], ss[7:0], ms[3:0]} in BCD.

Ports:
- `clk`, in, 1: system clock (`sys_clk`, 6.25 MHz).
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `btn_ss`, in, 1: start/stop press, a one-cycle pulse from a button press unit.
- `btn_lap`, in, 1: lap/reset press, a one-cycle pulse.
- `q_mm`, in, 8: live minutes (BCD).
- `q_ss`, in, 8: live seconds (BCD).
- `q_ms`, in, 4: live tenths.
- `clear`, out, 1: one-cycle counter clear pulse.
- `count`, out, 1: counter enable.
- `stop`, out, 1: counter hold; always equals `~count`.
- `disp_mm`, out, 8: minutes to the display.
- `disp_ss`, out, 8: seconds to the display.
- `disp_ms`, out, 4: tenths to the display.
- `disp_src`, out, 2: display source. 0 = live, 1 = split, 2 = recall.
- `lap_cnt`, out, $clog2(LAPS+1): number of laps stored.
- `lap_idx`, out, $clog2(LAPS): lap currently being recalled.
- `lap_full`, out, 1: high when `lap_cnt == LAPS`.

## Operation
The controller is a five-state machine: IDLE, RUN, SPLIT, HALT, RECALL.

State transitions:
- **IDLE:**
  - `btn_ss` → RUN.
  - `btn_lap` → stay in IDLE and pulse `clear`.
- **RUN:**
  - `btn_ss` → HALT.
  - `btn_lap` → SPLIT. The live time is latched into the split register. If `lap_cnt < LAPS`, the time is also written to `store[lap_cnt]` and `lap_cnt` increments.
  - When the store is full, the split is still latched and displayed but not stored; `lap_cnt` holds.
- **SPLIT:**
  - The counter keeps running; the display stays frozen on the split.
  - `btn_lap` → RUN (release only, nothing is captured).
  - `btn_ss` → HALT.
- **HALT:**
  - `btn_ss` → RUN (resume; the time is not cleared).
  - `btn_lap` with `lap_cnt > 0` → RECALL with `lap_idx` = 0.
  - `btn_lap` with `lap_cnt == 0` → IDLE and pulse `clear`.
- **RECALL:**
  - `btn_lap` with `lap_idx < lap_cnt-1` → increment `lap_idx`.
  - `btn_lap` on the last lap → IDLE, pulse `clear`, set `lap_cnt` to 0 and `lap_idx` to 0.
  - `btn_ss` → HALT; lap contents are kept.

Counter control:
- `count` is 1 in RUN and SPLIT and 0 otherwise.
- Entering IDLE always pulses `clear` for one cycle.

Display source:
- IDLE, RUN, HALT: live time, `disp_src` = 0.
- SPLIT: split register, `disp_src` = 1.
- RECALL: `store[lap_idx]`, `disp_src` = 2.

Simultaneous or invalid inputs:
- If `btn_ss` and `btn_lap` arrive in the same cycle, `btn_ss` wins and `btn_lap` is dropped.
- Button pulses that are not listed above for a state are ignored.

## Timing
- All outputs are registered.
- State, `count`, `stop` and `disp_src` update on the clock edge that samples the button pulse. This is 1 cycle of latency.
- `clear` is high for exactly the one cycle after that edge.
- Captured lap value: the `q_*` inputs sampled on the same edge as `btn_lap`.
- Display latency: `disp_*` = the selected source registered once, so live time appears on the display 1 cycle late.
- On `reset_n` low, asynchronously:
  - state = IDLE
  - `clear` = 1 (the counter has no reset; `clear` drops on the first edge after release)
  - `count` = 0, `stop` = 1
  - `disp_*` = 0, `disp_src` = 0
  - `lap_cnt` = 0, `lap_idx` = 0, `lap_full` = 0
  - split register = 0
- Store contents are not reset; they are unreachable while `lap_cnt` is 0.
- Reset asserted mid-RUN or mid-RECALL aborts immediately. No partial store write completes on that edge.
- `lap_idx` never exceeds `lap_cnt-1`.
- Counter wrap-around (59:59.9 → 00:00.0) is the counter's concern; the controller captures whatever value is live.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the state enum (IDLE=0, RUN=1, SPLIT=2, HALT=3, RECALL=4, 3-bit);
  - the `LAP_W` constant;
  - the `disp_src` codes;
  - the lap record field offsets.
- Sub-module `lap_store` is a `LAPS`×`LAP_W` register file with a synchronous write port (`we`, `waddr`, `wdata`) and an asynchronous read port (`raddr`, `rdata`).
- The FSM, split register and display mux stay in the top of this block.

## Test plan
- Reset, then IDLE → `clear` high for 1 cycle after release. `btn_ss` → `count`=1 the next cycle and `disp` tracks live. `btn_ss` again → `count`=0, `disp_src`=0.
- RUN at 01:23.4, `btn_lap` → `disp`=01:23.4 frozen, `disp_src`=1, `count`=1, `lap_cnt`=1. `btn_lap` again → `disp_src`=0 and `disp` live.
- `LAPS`=4, capture 5 laps in RUN → `lap_cnt`=4, `lap_full`=1. The 5th split is displayed, but `store[3]` still holds the 4th lap.
- HALT with 3 laps → `btn_lap` ×3 shows laps 0, 1, 2 (`disp_src`=2). The 4th `btn_lap` → IDLE, `clear` pulse, `lap_cnt`=0.
- `btn_ss` and `btn_lap` in the same cycle while in RUN → HALT and no lap captured (`lap_cnt` unchanged). In HALT with `lap_cnt`=0, `btn_lap` → IDLE with `clear`.
- `reset_n` low while in SPLIT with `lap_cnt`=2 → all outputs go to reset values immediately, asynchronously, including `clear`=1.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch lap/mode controller:
//   - state_t      : controller state encoding (3-bit)
//   - LAP_W        : lap record width, packed {mm[7:0], ss[7:0], ms[3:0]} in BCD
//   - MS/SS/MM_LSB : field offsets inside a lap record
//   - SRC_*        : disp_src codes (live / split / recall)
//   - pack_lap()   : builds a lap record from the three BCD fields
package stopwatch_pkg;

  localparam int LAP_W  = 20;

  localparam int MS_LSB = 0;
  localparam int SS_LSB = 4;
  localparam int MM_LSB = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SPLIT  = 3'd2,
    ST_HALT   = 3'd3,
    ST_RECALL = 3'd4
  } state_t;

  localparam logic [1:0] SRC_LIVE   = 2'd0;
  localparam logic [1:0] SRC_SPLIT  = 2'd1;
  localparam logic [1:0] SRC_RECALL = 2'd2;

  function automatic logic [LAP_W-1:0] pack_lap(input logic [7:0] mm,
                                                input logic [7:0] ss,
                                                input logic [3:0] ms);
    return {mm, ss, ms};
  endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_if.sv
// stopwatch_lap_ctrl_if
// Bundles the controller's button inputs, live time inputs and all of its
// counter-control / display outputs.
//   master : the environment side (drives buttons and live time)
//   slave  : the controller side (drives clear/count/stop, display, lap status)
// Parameter LAPS sizes lap_cnt ($clog2(LAPS+1)) and lap_idx ($clog2(LAPS)).
interface stopwatch_lap_ctrl_if #(
  parameter int LAPS = 4
);
  localparam int CNT_W = $clog2(LAPS + 1);
  localparam int IDX_W = (LAPS > 1) ? $clog2(LAPS) : 1;

  logic             btn_ss;
  logic             btn_lap;
  logic [7:0]       q_mm;
  logic [7:0]       q_ss;
  logic [3:0]       q_ms;
  logic             clear;
  logic             count;
  logic             stop;
  logic [7:0]       disp_mm;
  logic [7:0]       disp_ss;
  logic [3:0]       disp_ms;
  logic [1:0]       disp_src;
  logic [CNT_W-1:0] lap_cnt;
  logic [IDX_W-1:0] lap_idx;
  logic             lap_full;

  modport master (
    output btn_ss, btn_lap, q_mm, q_ss, q_ms,
    input  clear, count, stop, disp_mm, disp_ss, disp_ms,
           disp_src, lap_cnt, lap_idx, lap_full
  );

  modport slave (
    input  btn_ss, btn_lap, q_mm, q_ss, q_ms,
    output clear, count, stop, disp_mm, disp_ss, disp_ms,
           disp_src, lap_cnt, lap_idx, lap_full
  );

endinterface

// File: rtl/lap_store.sv
// lap_store
// LAPS x LAP_W register file holding captured lap times.
//   clk   : clock
//   we    : write enable, write happens on the rising edge
//   waddr : write address
//   wdata : lap record to write
//   raddr : read address (asynchronous read)
//   rdata : lap record at raddr
// Contents have no reset; the controller never reads a slot it has not written.
module lap_store #(
  parameter int LAPS  = 4,
  parameter int LAP_W = 20,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [LAP_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [LAP_W-1:0] rdata
);

  logic [LAP_W-1:0] mem [LAPS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl
// Two-button stopwatch mode controller (start/stop + lap/reset).
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus.btn_ss   : start/stop press pulse
//   bus.btn_lap  : lap/reset press pulse
//   bus.q_*      : live BCD time from the counter
//   bus.clear    : one-cycle counter clear (also held during reset)
//   bus.count    : counter enable, bus.stop = ~count
//   bus.disp_*   : time shown on the display, bus.disp_src selects its origin
//   bus.lap_cnt / lap_idx / lap_full : lap store status and recall pointer
module stopwatch_lap_ctrl #(
  parameter int LAPS  = 4,
  parameter int LAP_W = stopwatch_pkg::LAP_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  stopwatch_lap_ctrl_if.slave  bus
);
  import stopwatch_pkg::*;

  localparam int CNT_W = $clog2(LAPS + 1);
  localparam int IDX_W = (LAPS > 1) ? $clog2(LAPS) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lap_cnt, lap_cnt_nxt;
  logic [IDX_W-1:0] lap_idx, lap_idx_nxt;
  logic [LAP_W-1:0] split_q, split_nxt;
  logic [LAP_W-1:0] disp_q, disp_nxt;
  logic [LAP_W-1:0] live, rdata;
  logic [1:0]       src_q, src_nxt;
  logic             clear_q, clear_nxt;
  logic             count_q, full_q;
  logic             we;
  logic             ss_press, lap_press;

  // Start/stop wins over lap when both arrive in the same cycle.
  assign ss_press  = bus.btn_ss;
  assign lap_press = bus.btn_lap & ~bus.btn_ss;
  assign live      = pack_lap(bus.q_mm, bus.q_ss, bus.q_ms);

  // The store is written only on a RUN capture with free space; the read port
  // follows the next recall index so the display shows the lap on the same
  // edge that selects it.
  lap_store #(
    .LAPS  (LAPS),
    .LAP_W (LAP_W),
    .AW    (IDX_W)
  ) u_store (
    .clk   (clk),
    .we    (we),
    .waddr (lap_cnt[IDX_W-1:0]),
    .wdata (live),
    .raddr (lap_idx_nxt),
    .rdata (rdata)
  );

  // Next-state and next-output decode; every output register below loads the
  // value derived here so all outputs change on the edge that sees the press.
  always_comb begin
    state_nxt   = state;
    lap_cnt_nxt = lap_cnt;
    lap_idx_nxt = lap_idx;
    split_nxt   = split_q;
    clear_nxt   = 1'b0;
    we          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_press)       state_nxt = ST_RUN;
        else if (lap_press) clear_nxt = 1'b1;
      end
      ST_RUN: begin
        if (ss_press) state_nxt = ST_HALT;
        else if (lap_press) begin
          state_nxt = ST_SPLIT;
          split_nxt = live;
          if (lap_cnt < CNT_W'(LAPS)) begin
            we          = 1'b1;
            lap_cnt_nxt = lap_cnt + CNT_W'(1);
          end
        end
      end
      ST_SPLIT: begin
        if (ss_press)       state_nxt = ST_HALT;
        else if (lap_press) state_nxt = ST_RUN;
      end
      ST_HALT: begin
        if (ss_press) state_nxt = ST_RUN;
        else if (lap_press) begin
          if (lap_cnt != '0) begin
            state_nxt   = ST_RECALL;
            lap_idx_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
            clear_nxt = 1'b1;
          end
        end
      end
      ST_RECALL: begin
        if (ss_press) state_nxt = ST_HALT;
        else if (lap_press) begin
          if (CNT_W'(lap_idx) + CNT_W'(1) < lap_cnt) begin
            lap_idx_nxt = lap_idx + IDX_W'(1);
          end else begin
            state_nxt   = ST_IDLE;
            clear_nxt   = 1'b1;
            lap_cnt_nxt = '0;
            lap_idx_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        clear_nxt = 1'b1;
      end
    endcase

    case (state_nxt)
      ST_SPLIT: begin
        src_nxt  = SRC_SPLIT;
        disp_nxt = split_nxt;
      end
      ST_RECALL: begin
        src_nxt  = SRC_RECALL;
        disp_nxt = rdata;
      end
      default: begin
        src_nxt  = SRC_LIVE;
        disp_nxt = live;
      end
    endcase
  end

  // Controller state and registered outputs. clear is held high in reset
  // because the counter itself has no reset input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      clear_q <= 1'b1;
      count_q <= 1'b0;
      src_q   <= SRC_LIVE;
      disp_q  <= '0;
      lap_cnt <= '0;
      lap_idx <= '0;
      full_q  <= 1'b0;
      split_q <= '0;
    end else begin
      state   <= state_nxt;
      clear_q <= clear_nxt;
      count_q <= (state_nxt == ST_RUN) || (state_nxt == ST_SPLIT);
      src_q   <= src_nxt;
      disp_q  <= disp_nxt;
      lap_cnt <= lap_cnt_nxt;
      lap_idx <= lap_idx_nxt;
      full_q  <= (lap_cnt_nxt == CNT_W'(LAPS));
      split_q <= split_nxt;
    end
  end

  assign bus.clear    = clear_q;
  assign bus.count    = count_q;
  assign bus.stop     = ~count_q;
  assign bus.disp_mm  = disp_q[MM_LSB +: 8];
  assign bus.disp_ss  = disp_q[SS_LSB +: 8];
  assign bus.disp_ms  = disp_q[MS_LSB +: 4];
  assign bus.disp_src = src_q;
  assign bus.lap_cnt  = lap_cnt;
  assign bus.lap_idx  = lap_idx;
  assign bus.lap_full = full_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb_stopwatch_lap_ctrl
// Directed, table-driven bench for stopwatch_lap_ctrl with LAPS = 4.
// Each table record is one clock of button/live-time stimulus followed by the
// outputs expected after that edge; hand sequences cover asynchronous reset.
module tb_stopwatch_lap_ctrl;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  stopwatch_lap_ctrl_if #(.LAPS(4)) bus ();

  stopwatch_lap_ctrl #(.LAPS(4), .LAP_W(20)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #80 clk = ~clk;

  typedef struct {
    bit          ss;
    bit          lap;
    logic [19:0] q;
    bit          e_count;
    bit          e_clear;
    logic [1:0]  e_src;
    logic [2:0]  e_cnt;
    logic [1:0]  e_idx;
    bit          e_full;
    logic [19:0] e_disp;
  } vec_t;

  vec_t vecs[$];

  // Queue one table record: inputs, then expected outputs after the edge.
  task automatic add(input bit ss, input bit lap, input logic [19:0] q,
                     input bit e_count, input bit e_clear, input logic [1:0] e_src,
                     input logic [2:0] e_cnt, input logic [1:0] e_idx,
                     input bit e_full, input logic [19:0] e_disp);
    vec_t v;
    v.ss = ss; v.lap = lap; v.q = q;
    v.e_count = e_count; v.e_clear = e_clear; v.e_src = e_src;
    v.e_cnt = e_cnt; v.e_idx = e_idx; v.e_full = e_full; v.e_disp = e_disp;
    vecs.push_back(v);
  endtask

  // Called at a falling edge: drive inputs, let one rising edge sample them,
  // return at the next falling edge with the button pulses removed.
  task automatic applyStimulus(input bit ss, input bit lap, input logic [19:0] q);
    bus.btn_ss  = ss;
    bus.btn_lap = lap;
    bus.q_mm    = q[19:12];
    bus.q_ss    = q[11:4];
    bus.q_ms    = q[3:0];
    @(posedge clk);
    @(negedge clk);
    bus.btn_ss  = 1'b0;
    bus.btn_lap = 1'b0;
  endtask

  task automatic checkOutput(input string name, input bit e_count, input bit e_clear,
                             input logic [1:0] e_src, input logic [2:0] e_cnt,
                             input logic [1:0] e_idx, input bit e_full,
                             input logic [19:0] e_disp);
    logic [19:0] d;
    d = {bus.disp_mm, bus.disp_ss, bus.disp_ms};
    n_vec++;
    if (bus.count !== e_count || bus.stop !== ~e_count || bus.clear !== e_clear ||
        bus.disp_src !== e_src || bus.lap_cnt !== e_cnt || bus.lap_idx !== e_idx ||
        bus.lap_full !== e_full || d !== e_disp) begin
      n_err++;
      $display("[TB] FAIL %s: got count=%b stop=%b clear=%b src=%0d cnt=%0d idx=%0d full=%b disp=%05h; want count=%b stop=%b clear=%b src=%0d cnt=%0d idx=%0d full=%b disp=%05h",
               name, bus.count, bus.stop, bus.clear, bus.disp_src, bus.lap_cnt,
               bus.lap_idx, bus.lap_full, d, e_count, ~e_count, e_clear, e_src,
               e_cnt, e_idx, e_full, e_disp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n     = 1'b0;
    bus.btn_ss  = 1'b0;
    bus.btn_lap = 1'b0;
    bus.q_mm    = 8'h00;
    bus.q_ss    = 8'h00;
    bus.q_ms    = 4'h0;

    //   ss lap q         cnt clr src lc idx full disp
    // Basic start/stop and first split/release
    add(0, 0, 20'h00000, 0, 0, 0, 0, 0, 0, 20'h00000); // 0 idle, clear drops
    add(1, 0, 20'h00000, 1, 0, 0, 0, 0, 0, 20'h00000); // 1 -> RUN
    add(0, 0, 20'h01234, 1, 0, 0, 0, 0, 0, 20'h01234); // 2 live tracks
    add(0, 1, 20'h01234, 1, 0, 1, 1, 0, 0, 20'h01234); // 3 split, lap0
    add(0, 0, 20'h01250, 1, 0, 1, 1, 0, 0, 20'h01234); // 4 frozen
    add(0, 1, 20'h01261, 1, 0, 0, 1, 0, 0, 20'h01261); // 5 release
    add(0, 1, 20'h02000, 1, 0, 1, 2, 0, 0, 20'h02000); // 6 split, lap1
    add(0, 1, 20'h02010, 1, 0, 0, 2, 0, 0, 20'h02010); // 7 release
    add(0, 1, 20'h03105, 1, 0, 1, 3, 0, 0, 20'h03105); // 8 split, lap2
    add(1, 0, 20'h03110, 0, 0, 0, 3, 0, 0, 20'h03110); // 9 SPLIT -> HALT
    add(1, 0, 20'h03110, 1, 0, 0, 3, 0, 0, 20'h03110); // 10 resume RUN
    add(1, 1, 20'h03120, 0, 0, 0, 3, 0, 0, 20'h03120); // 11 both: HALT, no capture
    // Recall walk, escape to HALT, walk again to IDLE
    add(0, 1, 20'h03125, 0, 0, 2, 3, 0, 0, 20'h01234); // 12 recall lap0
    add(0, 1, 20'h03125, 0, 0, 2, 3, 1, 0, 20'h02000); // 13 recall lap1
    add(1, 0, 20'h03125, 0, 0, 0, 3, 1, 0, 20'h03125); // 14 back to HALT
    add(0, 1, 20'h03125, 0, 0, 2, 3, 0, 0, 20'h01234); // 15 recall lap0
    add(0, 1, 20'h03125, 0, 0, 2, 3, 1, 0, 20'h02000); // 16 lap1
    add(0, 1, 20'h03125, 0, 0, 2, 3, 2, 0, 20'h03105); // 17 lap2
    add(0, 1, 20'h03125, 0, 1, 0, 0, 0, 0, 20'h03125); // 18 last -> IDLE, clear
    add(0, 0, 20'h00000, 0, 0, 0, 0, 0, 0, 20'h00000); // 19 clear one cycle
    add(0, 1, 20'h00000, 0, 1, 0, 0, 0, 0, 20'h00000); // 20 lap in IDLE
    add(0, 0, 20'h00000, 0, 0, 0, 0, 0, 0, 20'h00000); // 21
    add(1, 0, 20'h00000, 1, 0, 0, 0, 0, 0, 20'h00000); // 22 RUN
    add(1, 0, 20'h00050, 0, 0, 0, 0, 0, 0, 20'h00050); // 23 HALT, no laps
    add(0, 1, 20'h00050, 0, 1, 0, 0, 0, 0, 20'h00050); // 24 -> IDLE, clear
    add(0, 0, 20'h00000, 0, 0, 0, 0, 0, 0, 20'h00000); // 25
    // Fill the store and overflow it with a fifth split
    add(1, 0, 20'h10000, 1, 0, 0, 0, 0, 0, 20'h10000); // 26 RUN
    add(0, 1, 20'h10011, 1, 0, 1, 1, 0, 0, 20'h10011); // 27 lap0
    add(0, 1, 20'h10020, 1, 0, 0, 1, 0, 0, 20'h10020); // 28
    add(0, 1, 20'h10031, 1, 0, 1, 2, 0, 0, 20'h10031); // 29 lap1
    add(0, 1, 20'h10040, 1, 0, 0, 2, 0, 0, 20'h10040); // 30
    add(0, 1, 20'h10052, 1, 0, 1, 3, 0, 0, 20'h10052); // 31 lap2
    add(0, 1, 20'h10060, 1, 0, 0, 3, 0, 0, 20'h10060); // 32
    add(0, 1, 20'h10073, 1, 0, 1, 4, 0, 1, 20'h10073); // 33 lap3, full
    add(0, 1, 20'h10080, 1, 0, 0, 4, 0, 1, 20'h10080); // 34
    add(0, 1, 20'h10094, 1, 0, 1, 4, 0, 1, 20'h10094); // 35 5th split shown only
    add(1, 0, 20'h10100, 0, 0, 0, 4, 0, 1, 20'h10100); // 36 HALT
    add(0, 1, 20'h10100, 0, 0, 2, 4, 0, 1, 20'h10011); // 37 recall lap0
    add(0, 1, 20'h10100, 0, 0, 2, 4, 1, 1, 20'h10031); // 38
    add(0, 1, 20'h10100, 0, 0, 2, 4, 2, 1, 20'h10052); // 39
    add(0, 1, 20'h10100, 0, 0, 2, 4, 3, 1, 20'h10073); // 40 store[3] kept 4th lap
    add(0, 1, 20'h10100, 0, 1, 0, 0, 0, 0, 20'h10100); // 41 -> IDLE, all cleared

    // Reset values, checked away from any clock edge
    #200;
    checkOutput("reset", 0, 1, 0, 0, 0, 0, 20'h00000);

    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ss, vecs[i].lap, vecs[i].q);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_clear,
                  vecs[i].e_src, vecs[i].e_cnt, vecs[i].e_idx, vecs[i].e_full,
                  vecs[i].e_disp);
    end

    // Asynchronous reset while in SPLIT with two laps stored
    applyStimulus(1, 0, 20'h20000);
    applyStimulus(0, 1, 20'h20011);
    applyStimulus(0, 1, 20'h20020);
    applyStimulus(0, 1, 20'h20033);
    checkOutput("pre_reset_split", 1, 0, 1, 2, 0, 0, 20'h20033);
    #30;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", 0, 1, 0, 0, 0, 0, 20'h00000);
    @(negedge clk);
    checkOutput("reset_held", 0, 1, 0, 0, 0, 0, 20'h00000);
    reset_n = 1'b1;
    applyStimulus(0, 0, 20'h00000);
    checkOutput("reset_release", 0, 0, 0, 0, 0, 0, 20'h00000);
    applyStimulus(1, 0, 20'h00012);
    checkOutput("post_reset_run", 1, 0, 0, 0, 0, 0, 20'h00012);
    applyStimulus(1, 0, 20'h00020);
    checkOutput("post_reset_halt", 0, 0, 0, 0, 0, 0, 20'h00020);
    applyStimulus(0, 1, 20'h00020);
    checkOutput("post_reset_lap_clear", 0, 1, 0, 0, 0, 0, 20'h00020);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
